// File: rtl/vga_bounce_core_if.sv
// Video-side bundle of vga_bounce_core: switch inputs plus sync, colour and position outputs.
// master = the video engine, slave = whatever watches the VGA connector and drives the switches.
interface vga_bounce_core_if;
   logic       sw0;
   logic       sw1;
   logic       HSYNC;
   logic       VSYNC;
   logic [4:0] R;
   logic [5:0] G;
   logic [4:0] B;
   logic [9:0] hPos;
   logic [9:0] vPos;
   logic       videoOn;

   modport master (
      input  sw0, sw1,
      output HSYNC, VSYNC, R, G, B, hPos, vPos, videoOn
   );

   modport slave (
      output sw0, sw1,
      input  HSYNC, VSYNC, R, G, B, hPos, vPos, videoOn
   );
endinterface

// File: rtl/vga_bounce_core.sv
// VGA 640x480@60 timing plus a bouncing square ball on a blue field, RGB565 out.
// CLK_DIV2_EN: pixel tick on every second CLK cycle; undefined: a pixel tick on every cycle.
module vga_bounce_core #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter int unsigned BALL_SIZE = 16
) (
   input  logic              CLK,
   input  logic              rst,
   vga_bounce_core_if.master vga
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0]  HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]  HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [9:0]  X_LIM    = 10'(H_ACTIVE - BALL_SIZE);
   localparam logic [9:0]  Y_LIM    = 10'(V_ACTIVE - BALL_SIZE);
   localparam logic [9:0]  X_RST    = 10'((H_ACTIVE - BALL_SIZE) / 2);
   localparam logic [9:0]  Y_RST    = 10'((V_ACTIVE - BALL_SIZE) / 2);
   localparam logic [10:0] BALL_W   = 11'(BALL_SIZE);

   logic pix_en;

`ifdef CLK_DIV2_EN
   logic pix_phase_q;

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) pix_phase_q <= 1'b0;
      else      pix_phase_q <= ~pix_phase_q;
   end

   assign pix_en = pix_phase_q;
`else
   assign pix_en = 1'b1;
`endif

   logic [1:0] sw0_sync_q, sw1_sync_q;
   logic       pause, fast;

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         sw0_sync_q <= 2'b00;
         sw1_sync_q <= 2'b00;
      end else begin
         sw0_sync_q <= {sw0_sync_q[0], vga.sw0};
         sw1_sync_q <= {sw1_sync_q[0], vga.sw1};
      end
   end

   assign pause = sw0_sync_q[1];
   assign fast  = sw1_sync_q[1];

   // One axis of motion; returns {dir, pos}. Clamps at the wall and reverses on contact.
   function automatic logic [10:0] axis_next(input logic [9:0] pos, input logic dir,
                                             input logic [9:0] lim, input logic [1:0] s);
      logic [10:0] sum;
      sum = {1'b0, pos} + {9'd0, s};
      if (dir) begin
         if (sum >= {1'b0, lim}) return {1'b0, lim};
         else                    return {1'b1, sum[9:0]};
      end else begin
         if (pos <= {8'd0, s}) return {1'b1, 10'd0};
         else                  return {1'b0, pos - {8'd0, s}};
      end
   endfunction

   logic [9:0]  h_q, h_d, v_q, v_d;
   logic [9:0]  bx_q, bx_d, by_q, by_d;
   logic        dx_q, dx_d, dy_q, dy_d;
   logic        hs_q, hs_d, vs_q, vs_d, von_q, von_d;
   logic [4:0]  r_q, r_d, b_q, b_d;
   logic [5:0]  g_q, g_d;
   logic        active, in_ball, frame_tick;
   logic [1:0]  step;
   logic [10:0] nx, ny;

   assign active  = (h_q < H_ACT) && (v_q < V_ACT);
   assign in_ball = (h_q >= bx_q) && ({1'b0, h_q} < ({1'b0, bx_q} + BALL_W)) &&
                    (v_q >= by_q) && ({1'b0, v_q} < ({1'b0, by_q} + BALL_W));
   // First tick of vertical blanking: the ball moves here so a frame never tears.
   assign frame_tick = pix_en && (h_q == '0) && (v_q == V_ACT) && !pause;
   assign step       = fast ? 2'd2 : 2'd1;
   assign nx         = axis_next(bx_q, dx_q, X_LIM, step);
   assign ny         = axis_next(by_q, dy_q, Y_LIM, step);

   always_comb begin
      h_d   = h_q;
      v_d   = v_q;
      hs_d  = hs_q;
      vs_d  = vs_q;
      von_d = von_q;
      r_d   = r_q;
      g_d   = g_q;
      b_d   = b_q;
      bx_d  = bx_q;
      by_d  = by_q;
      dx_d  = dx_q;
      dy_d  = dy_q;
      if (pix_en) begin
         h_d = (h_q == H_LAST) ? '0 : h_q + 10'd1;
         if (h_q == H_LAST) v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
         hs_d  = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
         vs_d  = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
         von_d = active;
         if (!active)     {r_d, g_d, b_d} = 16'h0000;
         else if (in_ball) {r_d, g_d, b_d} = 16'hFFFF;
         else              {r_d, g_d, b_d} = 16'h0010;
      end
      if (frame_tick) begin
         {dx_d, bx_d} = nx;
         {dy_d, by_d} = ny;
      end
   end

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         h_q   <= '0;
         v_q   <= '0;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
         von_q <= 1'b0;
         r_q   <= '0;
         g_q   <= '0;
         b_q   <= '0;
         bx_q  <= X_RST;
         by_q  <= Y_RST;
         dx_q  <= 1'b1;
         dy_q  <= 1'b1;
      end else begin
         h_q   <= h_d;
         v_q   <= v_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         von_q <= von_d;
         r_q   <= r_d;
         g_q   <= g_d;
         b_q   <= b_d;
         bx_q  <= bx_d;
         by_q  <= by_d;
         dx_q  <= dx_d;
         dy_q  <= dy_d;
      end
   end

   assign vga.hPos    = h_q;
   assign vga.vPos    = v_q;
   assign vga.HSYNC   = hs_q;
   assign vga.VSYNC   = vs_q;
   assign vga.videoOn = von_q;
   assign vga.R       = r_q;
   assign vga.G       = g_q;
   assign vga.B       = b_q;

endmodule

// File: tb/tb_vga_bounce_core.sv
// Bench for vga_bounce_core: full-size instance for reset and line timing, plus a shrunken
// timing instance (30x26 ticks/frame, 4x4 ball) scanned frame by frame for ball motion.
`timescale 1ns/1ps
module tb_vga_bounce_core;
`ifdef CLK_DIV2_EN
   localparam int TC = 2;
`else
   localparam int TC = 1;
`endif
   localparam int S_HA = 24, S_HFP = 2, S_HS = 2, S_HBP = 2;
   localparam int S_VA = 22, S_VFP = 1, S_VS = 2, S_VBP = 1;
   localparam int S_BALL = 4;
   localparam int S_FRAME = (S_HA + S_HFP + S_HS + S_HBP) * (S_VA + S_VFP + S_VS + S_VBP);
   localparam int NF = 24;

   logic CLK = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 CLK = ~CLK;

   vga_bounce_core_if big_if ();
   vga_bounce_core_if sml_if ();

   vga_bounce_core u_big (
      .CLK (CLK),
      .rst (rst),
      .vga (big_if)
   );

   vga_bounce_core #(
      .H_ACTIVE  (S_HA),
      .H_FP      (S_HFP),
      .H_SYNC    (S_HS),
      .H_BP      (S_HBP),
      .V_ACTIVE  (S_VA),
      .V_FP      (S_VFP),
      .V_SYNC    (S_VS),
      .V_BP      (S_VBP),
      .BALL_SIZE (S_BALL)
   ) u_sml (
      .CLK (CLK),
      .rst (rst),
      .vga (sml_if)
   );

   // Ball top-left expected in each frame (after f updates), worked out by hand.
   int exp_x [NF] = '{10, 11, 12, 13, 14, 15, 16, 17, 18, 20, 19, 19,
                      19, 19, 17, 15, 13, 11,  9,  7,  5,  3,  1,  0};
   int exp_y [NF] = '{ 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 17, 17,
                      17, 17, 15, 13, 11,  9,  7,  5,  3,  1,  0,  2};

   int fx [NF];
   int fy [NF];
   int fw [NF];
   int fbad [NF];
   int fper [NF];
   int fidx = 0;
   int last_h, last_v, min_x, min_y, whites, bad, since;

   // Pair each output sample with the position exposed one tick earlier.
   always @(negedge CLK) begin : mon
      int   ph, pv;
      logic act, in_hs, in_vs, white, blue, blank, ok;
      if (!rst) begin
         fidx   <= 0;
         last_h = 0;
         last_v = 0;
         min_x  = 1000;
         min_y  = 1000;
         whites = 0;
         bad    = 0;
         since  = 0;
      end else if (int'(sml_if.hPos) != last_h) begin
         ph     = last_h;
         pv     = last_v;
         last_h = int'(sml_if.hPos);
         last_v = int'(sml_if.vPos);
         since++;
         if (ph == 0 && pv == S_VA) begin
            if (fidx < NF) begin
               fx[fidx]   <= min_x;
               fy[fidx]   <= min_y;
               fw[fidx]   <= whites;
               fbad[fidx] <= bad;
               fper[fidx] <= since;
            end
            fidx   <= fidx + 1;
            min_x  = 1000;
            min_y  = 1000;
            whites = 0;
            bad    = 0;
            since  = 0;
         end
         act   = (ph < S_HA) && (pv < S_VA);
         in_hs = (ph >= S_HA + S_HFP) && (ph < S_HA + S_HFP + S_HS);
         in_vs = (pv >= S_VA + S_VFP) && (pv < S_VA + S_VFP + S_VS);
         white = (sml_if.R == 5'd31) && (sml_if.G == 6'd63) && (sml_if.B == 5'd31);
         blue  = (sml_if.R == 5'd0) && (sml_if.G == 6'd0) && (sml_if.B == 5'd16);
         blank = (sml_if.R == 5'd0) && (sml_if.G == 6'd0) && (sml_if.B == 5'd0);
         ok = (sml_if.HSYNC == !in_hs) && (sml_if.VSYNC == !in_vs) && (sml_if.videoOn == act);
         ok = ok && (act ? (white || blue) : blank);
         if (!ok) bad++;
         if (white) begin
            whites++;
            if (ph < min_x) min_x = ph;
            if (pv < min_y) min_y = pv;
         end
      end
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_hs(input logic lvl, output int cyc);
      cyc = 0;
      do begin
         @(negedge CLK);
         cyc++;
      end while (big_if.HSYNC !== lvl && cyc < 4000 * TC);
   endtask

   task automatic wait_big_h(input int h);
      int n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (int'(big_if.hPos) != h && n < 4000 * TC);
      check_eq($sformatf("reach_hpos_%0d", h), int'(big_if.hPos), h);
   endtask

   task automatic wait_frames(input int n);
      int k = 0;
      while (fidx < n && k < 20000 * TC) begin
         @(negedge CLK);
         k++;
      end
      check_eq($sformatf("frames_reached_%0d", n), (fidx >= n) ? 1 : 0, 1);
   endtask

   task automatic set_sw(input logic s0, input logic s1);
      sml_if.sw0 = s0;
      sml_if.sw1 = s1;
      big_if.sw0 = s0;
      big_if.sw1 = s1;
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int c0, c1, c2;
      set_sw(1'b0, 1'b0);
      #1 rst = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check_eq("rst_hpos", int'(big_if.hPos), 0);
      check_eq("rst_vpos", int'(big_if.vPos), 0);
      check_eq("rst_hsync", int'(big_if.HSYNC), 1);
      check_eq("rst_vsync", int'(big_if.VSYNC), 1);
      check_eq("rst_videoon", int'(big_if.videoOn), 0);
      check_eq("rst_rgb", int'({big_if.R, big_if.G, big_if.B}), 0);

      @(negedge CLK) rst = 1'b1;
      repeat (50) @(negedge CLK);
      check_eq("run_hpos", int'(big_if.hPos), 50 / TC);
      check_eq("run_rgb_blue", int'({big_if.R, big_if.G, big_if.B}), 16);

      // Mid-line reset: everything clears at once, without waiting for a clock edge.
      rst = 1'b0;
      #1;
      check_eq("midrst_hpos", int'(big_if.hPos), 0);
      check_eq("midrst_videoon", int'(big_if.videoOn), 0);
      check_eq("midrst_rgb", int'({big_if.R, big_if.G, big_if.B}), 0);
      check_eq("midrst_small_hpos", int'(sml_if.hPos), 0);
      repeat (3) @(posedge CLK);
      #1;
      check_eq("midrst_hold_hpos", int'(big_if.hPos), 0);
      check_eq("midrst_hold_hsync", int'(big_if.HSYNC), 1);
      @(negedge CLK) rst = 1'b1;
`ifdef CLK_DIV2_EN
      @(posedge CLK);
      #1 check_eq("first_edge_idle", int'(big_if.hPos), 0);
`endif
      @(posedge CLK);
      #1 check_eq("hpos_step_1", int'(big_if.hPos), 1);
      for (int i = 2; i <= 3; i++) begin
         repeat (TC) @(posedge CLK);
         #1 check_eq($sformatf("hpos_step_%0d", i), int'(big_if.hPos), i);
      end

      wait_hs(1'b0, c0);
      check_eq("hs_fall_hpos", int'(big_if.hPos), 657);
      wait_hs(1'b1, c1);
      check_eq("hs_low_cycles", c1, 96 * TC);
      check_eq("hs_rise_hpos", int'(big_if.hPos), 753);
      wait_hs(1'b0, c2);
      check_eq("line_cycles", c1 + c2, 800 * TC);
      check_eq("line2_vpos", int'(big_if.vPos), 1);

      wait_big_h(101);
      check_eq("pix_100_2_vpos", int'(big_if.vPos), 2);
      check_eq("pix_100_2_rgb", int'({big_if.R, big_if.G, big_if.B}), 16);
      check_eq("pix_100_2_videoon", int'(big_if.videoOn), 1);
      wait_big_h(701);
      check_eq("pix_700_2_rgb", int'({big_if.R, big_if.G, big_if.B}), 0);
      check_eq("pix_700_2_videoon", int'(big_if.videoOn), 0);

      wait_frames(8);
      set_sw(1'b0, 1'b1);
      wait_frames(9);
      set_sw(1'b0, 1'b0);
      wait_frames(10);
      set_sw(1'b1, 1'b0);
      wait_frames(13);
      set_sw(1'b0, 1'b1);
      wait_frames(NF);
      @(negedge CLK);

      for (int f = 0; f < NF; f++) begin
         check_eq($sformatf("frame%0d_ball_x", f), fx[f], exp_x[f]);
         check_eq($sformatf("frame%0d_ball_y", f), fy[f], exp_y[f]);
         check_eq($sformatf("frame%0d_white_px", f), fw[f], S_BALL * S_BALL);
         check_eq($sformatf("frame%0d_bad_px", f), fbad[f], 0);
         if (f > 0) check_eq($sformatf("frame%0d_ticks", f), fper[f], S_FRAME);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
